// File: rtl/fpga_bootrom_trampoline_if.sv
// Boot instruction port of the trampoline bootrom: read bus plus boot-target control.
// The master is the core/boot controller and the slave is the bootrom.
interface fpga_bootrom_trampoline_if #(
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  CEN;
  logic [ADDR_WIDTH-1:0] A;
  logic [31:0]           Q;
  logic                  BOOT_WE;
  logic [31:0]           BOOT_WDATA;
  logic                  BOOT_LOCK;
  logic [31:0]           BOOT_TARGET;
  logic                  BOOT_LOCKED;
  logic                  BOOT_DONE;

  modport master (
    output CEN, A, BOOT_WE, BOOT_WDATA, BOOT_LOCK,
    input  Q, BOOT_TARGET, BOOT_LOCKED, BOOT_DONE
  );

  modport slave (
    input  CEN, A, BOOT_WE, BOOT_WDATA, BOOT_LOCK,
    output Q, BOOT_TARGET, BOOT_LOCKED, BOOT_DONE
  );
endinterface

// File: rtl/fpga_bootrom_trampoline.sv
// Bootrom that serves a lui/addi/jalr trampoline to a runtime-programmable target,
// NOPs elsewhere; the target locks on request or on the first jalr fetch.
module fpga_bootrom_trampoline #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] BOOT_ADDR  = 32'h1C008080
) (
  input logic                       CLK,
  input logic                       RST,
  fpga_bootrom_trampoline_if.slave  bus
);

  localparam logic [31:0] BOOT_ADDR_ALIGNED = BOOT_ADDR & ~32'h3;
  localparam logic [31:0] INSN_NOP          = 32'h00000013;
  localparam logic [31:0] INSN_JALR         = 32'h00050067;

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("fpga_bootrom_trampoline: DATA_WIDTH must be 32");
  end
  if (ADDR_WIDTH < 2) begin : g_bad_addr_width
    $error("fpga_bootrom_trampoline: ADDR_WIDTH must be >= 2");
  end

  logic [31:0] r_q;
  logic [31:0] r_target;
  logic        r_locked;
  logic        r_done;

  logic [19:0] w_hi;
  logic [31:0] w_word0;
  logic [31:0] w_word1;
  logic [31:0] w_rdata;
  logic [31:0] w_wdata_aligned;
  logic        w_read;
  logic        w_jalr_fetch;

  // Rounding the upper immediate by bit 11 cancels the sign extension of addi's lo.
  assign w_hi    = r_target[31:12] + 20'(r_target[11]);
  assign w_word0 = {w_hi, 5'd10, 7'h37};
  assign w_word1 = {r_target[11:0], 5'd10, 3'b000, 5'd10, 7'h13};

  always_comb begin
    w_rdata = INSN_NOP;
    case (bus.A)
      ADDR_WIDTH'(0): w_rdata = w_word0;
      ADDR_WIDTH'(1): w_rdata = w_word1;
      ADDR_WIDTH'(2): w_rdata = INSN_JALR;
      default:        w_rdata = INSN_NOP;
    endcase
  end

  assign w_read          = ~bus.CEN;
  assign w_jalr_fetch    = w_read && (bus.A == ADDR_WIDTH'(2));
  assign w_wdata_aligned = bus.BOOT_WDATA & ~32'h3;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q      <= INSN_NOP;
      r_target <= BOOT_ADDR_ALIGNED;
      r_locked <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (w_read) begin
        r_q <= w_rdata;
      end
      // Lock is sampled pre-edge, so a write alongside a lock event still lands.
      if (bus.BOOT_WE && !r_locked) begin
        r_target <= w_wdata_aligned;
      end
      if (bus.BOOT_LOCK || w_jalr_fetch) begin
        r_locked <= 1'b1;
      end
      if (w_jalr_fetch) begin
        r_done <= 1'b1;
      end
    end
  end

  assign bus.Q           = r_q;
  assign bus.BOOT_TARGET = r_target;
  assign bus.BOOT_LOCKED = r_locked;
  assign bus.BOOT_DONE   = r_done;

endmodule
